gearbox_frame: RTL and testbench
================================

GEARBOX_FRAME -- requirements
Module: gearbox_frame

Interface
REQ-001 Parameter IN_W, default 32: input word width in bits.
REQ-002 Parameter OUT_W, default 20: output word width in bits.
REQ-003 Parameter FRAME_WORDS, default 5: input words per frame.
REQ-004 Parameter DROP_BITS, default 60: leading bits of each frame that are discarded.
REQ-005 clk  in  1: single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1: asynchronous reset, active-low.
REQ-007 in_data  in  IN_W: input word; bit 0 is the earliest bit in the frame.
REQ-008 in_valid  in  1: in_data is valid.
REQ-009 in_sof  in  1: qualified by in_valid; marks word 0 of a frame.
REQ-010 in_ready  out  1: block accepts in_data this cycle.
REQ-011 out_data  out  OUT_W: output word; bit 0 is the earliest bit.
REQ-012 out_valid  out  1: out_data is valid.
REQ-013 out_last  out  1: qualified by out_valid; marks the final beat of a frame.
REQ-014 out_ready  in  1: the sink accepts out_data this cycle.
REQ-015 frame_err  out  1: one-cycle pulse on a framing violation.

Function
REQ-016 The frame bit index of bit b of word k SHALL be k*IN_W+b; bits with index < DROP_BITS SHALL be discarded, and all other bits SHALL be kept in index order.
REQ-017 KEEP = FRAME_WORDS*IN_W - DROP_BITS; elaboration SHALL fail unless KEEP > 0, KEEP % OUT_W == 0 and DROP_BITS >= 0.
REQ-018 An input transfer SHALL occur when in_valid && in_ready.
REQ-019 An output transfer SHALL occur when out_valid && out_ready.
REQ-020 The accumulator SHALL hold IN_W+OUT_W bits with a fill counter.
REQ-021 in_ready SHALL be registered-state only (fill <= OUT_W) and SHALL have no combinational path from out_ready.
REQ-022 out_valid SHALL equal (fill >= OUT_W), and out_data SHALL be the accumulator's lowest OUT_W bits.
REQ-023 On a simultaneous push and pop: fill_next = fill - OUT_W + kept_bits(word_cnt), and the new kept bits SHALL land directly above the remaining bits after the shift.
REQ-024 A fully dropped word SHALL be accepted (subject to in_ready) without changing fill.
REQ-025 A partially dropped word SHALL contribute only its upper bits.
REQ-026 word_cnt SHALL advance 0..FRAME_WORDS-1 on each input transfer and wrap to 0.
REQ-027 beat_cnt SHALL count output transfers 0..KEEP/OUT_W-1 and wrap to 0; out_last = (beat_cnt == KEEP/OUT_W-1).
REQ-028 Latency: out_valid SHALL rise in the cycle after the input transfer that brings fill to >= OUT_W.
REQ-029 Once raised, out_valid SHALL hold with stable out_data until transferred, except on resync (REQ-031).
REQ-030 An input transfer with in_sof=0 while word_cnt==0 SHALL pulse frame_err; the word SHALL still be processed as word 0.
REQ-031 An input transfer with in_sof=1 while word_cnt!=0 SHALL:
- pulse frame_err;
- clear fill and beat_cnt, withdrawing any pending beat;
- process the word as word 0 of a new frame (resync).
REQ-032 With DROP_BITS=0 and OUT_W=IN_W the block SHALL pass one word per cycle at full throughput.

Reset
REQ-033 While rst_n=0 the block SHALL hold: in_ready=0, out_valid=0, out_last=0, out_data=0, frame_err=0, fill=0, word_cnt=0, beat_cnt=0.
REQ-034 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-035 Reset mid-frame SHALL discard all partial data; the next frame SHALL start with in_sof.

Structure
REQ-036 Package gearbox_pkg SHALL hold the default IN_W/OUT_W/FRAME_WORDS/DROP_BITS constants and a function computing kept_bits(word index).
REQ-037 Sub-module gear_accum SHALL contain the shift accumulator and fill counter (push count, pop flag, data in/out).
REQ-038 gearbox_frame SHALL contain the counters, the framing checks and the handshake logic.

Verification
REQ-039 Defaults, out_ready=1, words W0=any, W1=0xF0000000, W2=0x1234ABCD, W3=0x87654325, W4=0xCAFEB9AB, sof on W0 -> out beats 0xABCDF, 0x51234, 0x65432, 0x9AB87, 0xCAFEB; out_last only on 0xCAFEB; frame_err never.
REQ-040 Same stimulus with out_ready toggling 1/0 each cycle and in_valid random -> identical beat sequence, out_data stable while stalled, no loss or duplication.
REQ-041 in_sof=1 on the 3rd word of a frame -> frame_err pulse, pending beat withdrawn, next 5 words yield a correct frame.
REQ-042 Frame sent without in_sof on word 0 -> one frame_err pulse; data output unchanged versus REQ-039.
REQ-043 rst_n pulsed low after W2 -> out_valid=0 and in_ready=0 during reset; a following clean frame yields the REQ-039 beats.
REQ-044 IN_W=OUT_W=16, DROP_BITS=0, FRAME_WORDS=4, continuous input -> one beat per cycle, out_data equals in_data one cycle later, out_last every 4th beat.

Source files
------------

// File: rtl/gearbox_pkg.sv
// Shared defaults and frame-geometry helper for the frame gearbox.
package gearbox_pkg;

  localparam int DEF_IN_W        = 32;
  localparam int DEF_OUT_W       = 20;
  localparam int DEF_FRAME_WORDS = 5;
  localparam int DEF_DROP_BITS   = 60;

  // Number of bits of word idx that survive the leading-bit drop.
  function automatic int kept_bits(input int idx, input int in_w, input int drop_bits);
    int lo;
    int hi;
    lo = idx * in_w;
    hi = lo + in_w;
    if (hi <= drop_bits) return 0;
    else if (lo >= drop_bits) return in_w;
    else return hi - drop_bits;
  endfunction

endpackage

// File: rtl/gear_accum.sv
// Shift accumulator: appends push_cnt bits above the current fill and
// shifts out OUT_W bits from the bottom on pop.
module gear_accum
  import gearbox_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = $clog2(IN_W + OUT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [CNT_W-1:0] push_cnt,
  input  logic [IN_W-1:0]  push_data,
  input  logic             pop,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] fill
);

  localparam int ACC_W = IN_W + OUT_W;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] fill_q, fill_d;

  // push_data must be zero above push_cnt so the OR below cannot corrupt.
  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    if (clr) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (pop) begin
      acc_d  = acc_q >> OUT_W;
      fill_d = fill_q - CNT_W'(OUT_W);
    end
    if (push) begin
      acc_d  = acc_d | ({{OUT_W{1'b0}}, push_data} << fill_d);
      fill_d = fill_d + push_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  assign out_data = acc_q[OUT_W-1:0];
  assign fill     = fill_q;

endmodule

// File: rtl/gearbox_frame.sv
// Frame gearbox: drops the leading DROP_BITS of each FRAME_WORDS-word frame
// and repacks the remaining bits into OUT_W-bit beats.
module gearbox_frame
  import gearbox_pkg::*;
#(
  parameter int IN_W        = DEF_IN_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int DROP_BITS   = DEF_DROP_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             frame_err
);

  localparam int KEEP  = FRAME_WORDS * IN_W - DROP_BITS;
  localparam int BEATS = (KEEP > 0) ? KEEP / OUT_W : 1;
  localparam int CNT_W = $clog2(IN_W + OUT_W + 1);
  localparam int WC_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (KEEP <= 0 || (KEEP % OUT_W) != 0 || DROP_BITS < 0) begin : g_bad_cfg
    $error("gearbox_frame: kept bits must be positive and a multiple of OUT_W");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and in_ready depends only on flops.
  logic             run_q;
  logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
  logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] fill;
  logic [CNT_W-1:0] push_cnt;
  logic [IN_W-1:0]  push_data;
  logic [WC_W-1:0]  word_idx;
  logic             in_fire, out_fire, resync, miss_sof;
  int               kept;

  assign in_ready  = run_q && (fill <= CNT_W'(OUT_W));
  assign out_valid = (fill >= CNT_W'(OUT_W));
  assign out_last  = out_valid && (beat_cnt_q == BC_W'(BEATS - 1));
  assign frame_err = frame_err_q;

  always_comb begin
    in_fire     = in_valid && in_ready;
    out_fire    = out_valid && out_ready;
    resync      = in_fire && in_sof && (word_cnt_q != '0);
    miss_sof    = in_fire && !in_sof && (word_cnt_q == '0);
    word_idx    = resync ? '0 : word_cnt_q;
    kept        = kept_bits(int'(word_idx), IN_W, DROP_BITS);
    // Right-align the surviving upper bits of a partially dropped word.
    push_data   = in_data >> (IN_W - kept);
    push_cnt    = CNT_W'(kept);
    frame_err_d = resync || miss_sof;

    word_cnt_d = word_cnt_q;
    if (in_fire) begin
      word_cnt_d = (word_idx == WC_W'(FRAME_WORDS - 1)) ? '0 : word_idx + WC_W'(1);
    end

    beat_cnt_d = beat_cnt_q;
    if (resync) begin
      beat_cnt_d = '0;
    end else if (out_fire) begin
      beat_cnt_d = (beat_cnt_q == BC_W'(BEATS - 1)) ? '0 : beat_cnt_q + BC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      word_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      word_cnt_q  <= word_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  gear_accum #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (resync),
    .push      (in_fire),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop       (out_fire),
    .out_data  (out_data),
    .fill      (fill)
  );

endmodule

// File: tb/tb_gearbox_frame.sv
// Directed + randomized bench for gearbox_frame with a bit-list reference model.
module tb_gearbox_frame;
  import gearbox_pkg::*;

  localparam int IN_W  = 32;
  localparam int OUT_W = 20;
  localparam int FW    = 5;
  localparam int DROP  = 60;
  localparam int KEEP  = FW * IN_W - DROP;
  localparam int BEATS = KEEP / OUT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (defaults) ----------------
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_sof = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready = 1'b1;
  logic             frame_err;

  gearbox_frame dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  // ---------------- DUT (pass-through geometry) ----------------
  logic [15:0] in2_data = '0;
  logic        in2_valid = 1'b0;
  logic        in2_sof = 1'b0;
  logic        in2_ready;
  logic [15:0] out2_data;
  logic        out2_valid;
  logic        out2_last;
  logic        frame_err2;

  gearbox_frame #(
    .IN_W        (16),
    .OUT_W       (16),
    .FRAME_WORDS (4),
    .DROP_BITS   (0)
  ) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in2_data),
    .in_valid  (in2_valid),
    .in_sof    (in2_sof),
    .in_ready  (in2_ready),
    .out_data  (out2_data),
    .out_valid (out2_valid),
    .out_last  (out2_last),
    .out_ready (1'b1),
    .frame_err (frame_err2)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int or_mode = 0;
  logic [OUT_W:0]  exp_q[$];
  logic [IN_W-1:0] fr[FW];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: list the frame's bits in index order, drop the leading DROP,
  // and cut the survivors into OUT_W-bit beats; a partial frame yields only
  // its whole beats.
  task automatic model(input int n_words);
    bit bq[$];
    int beat;
    logic [OUT_W-1:0] d;
    beat = 0;
    for (int k = 0; k < n_words; k++)
      for (int b = 0; b < IN_W; b++)
        if (k * IN_W + b >= DROP) bq.push_back(fr[k][b]);
    while (bq.size() >= OUT_W) begin
      for (int i = 0; i < OUT_W; i++) d[i] = bq.pop_front();
      exp_q.push_back({(n_words == FW && beat == BEATS - 1), d});
      beat++;
    end
  endtask

  task automatic set_ref_frame();
    fr[0] = 32'h0BAD_F00D;
    fr[1] = 32'hF000_0000;
    fr[2] = 32'h1234_ABCD;
    fr[3] = 32'h8765_4325;
    fr[4] = 32'hCAFE_B9AB;
  endtask

  task automatic set_rand_frame();
    for (int k = 0; k < FW; k++) fr[k] = $urandom;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [IN_W-1:0] d, input logic sof, input bit gaps);
    int t;
    bit ok;
    t = 0;
    ok = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    while (!ok && t < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (!ok) chk("in_ready_wait", ok, 1);
  endtask

  task automatic send_frame(input int first, input logic sof0, input bit gaps);
    for (int k = first; k < FW; k++) send_word(fr[k], (k == 0) && sof0, gaps);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (or_mode == 1) out_ready = ~out_ready;
    else out_ready = 1'b1;
  end

  // ---------------- scoreboard / monitor ----------------
  logic [OUT_W-1:0] prev_d;
  logic             prev_v = 1'b0;
  logic             prev_r = 1'b0;
  logic [OUT_W:0]   e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_d);
      end
      if (frame_err) err_pulses++;
      if (out_valid && out_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e[OUT_W-1:0]);
          chk("out_last", out_last, e[OUT_W]);
        end
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
    end
  end

  // ---------------- directed sequence ----------------
  int e0;
  logic [15:0] d2, last_d2;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    // reference frame, sink always ready, with latency checks
    set_ref_frame();
    model(FW);
    send_word(fr[0], 1'b1, 1'b0);
    send_word(fr[1], 1'b0, 1'b0);
    @(negedge clk);
    chk("no_early_valid", out_valid, 0);
    @(posedge clk); #1;
    send_word(fr[2], 1'b0, 1'b0);
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    @(posedge clk); #1;
    send_frame(3, 1'b0, 1'b0);
    drain();
    chk("ref_no_err", err_pulses, 0);

    // stalling sink, gappy source, then random frames
    or_mode = 1;
    set_ref_frame();
    model(FW);
    send_frame(0, 1'b1, 1'b1);
    for (int f = 0; f < 3; f++) begin
      set_rand_frame();
      model(FW);
      send_frame(0, 1'b1, 1'b1);
    end
    drain();
    or_mode = 0;
    chk("stall_no_err", err_pulses, 0);

    // resync on the 3rd word: two words then a fresh frame
    e0 = err_pulses;
    set_ref_frame();
    model(2);
    send_word(fr[0], 1'b1, 1'b0);
    send_word(fr[1], 1'b0, 1'b0);
    model(FW);
    send_word(fr[0], 1'b1, 1'b0);
    @(negedge clk);
    chk("resync_pulse", frame_err, 1);
    chk("resync_withdrawn", out_valid, 0);
    @(posedge clk); #1;
    send_frame(1, 1'b0, 1'b0);
    drain();
    chk("resync_err_count", err_pulses - e0, 1);

    // resync after three words, one beat already emitted
    e0 = err_pulses;
    set_rand_frame();
    model(3);
    send_word(fr[0], 1'b1, 1'b0);
    send_word(fr[1], 1'b0, 1'b0);
    send_word(fr[2], 1'b0, 1'b0);
    set_rand_frame();
    model(FW);
    send_frame(0, 1'b1, 1'b0);
    drain();
    chk("resync3_err_count", err_pulses - e0, 1);

    // missing sof on word 0
    e0 = err_pulses;
    set_ref_frame();
    model(FW);
    send_frame(0, 1'b0, 1'b0);
    drain();
    chk("nosof_err_count", err_pulses - e0, 1);

    // reset after W2, then a clean frame
    e0 = err_pulses;
    set_ref_frame();
    model(3);
    send_word(fr[0], 1'b1, 1'b0);
    send_word(fr[1], 1'b0, 1'b0);
    send_word(fr[2], 1'b0, 1'b0);
    drain();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release_ready", in_ready, 1);
    model(FW);
    send_frame(0, 1'b1, 1'b0);
    drain();
    chk("midrst_err_count", err_pulses - e0, 0);

    // pass-through geometry: one beat per cycle, one cycle late
    last_d2 = '0;
    for (int i = 0; i < 16; i++) begin
      d2 = 16'($urandom);
      in2_data  = d2;
      in2_sof   = (i % 4 == 0);
      in2_valid = 1'b1;
      @(negedge clk);
      chk("d2_in_ready", in2_ready, 1);
      chk("d2_frame_err", frame_err2, 0);
      if (i > 0) begin
        chk("d2_valid", out2_valid, 1);
        chk("d2_data", out2_data, last_d2);
        chk("d2_last", out2_last, ((i - 1) % 4) == 3);
      end
      last_d2 = d2;
      @(posedge clk); #1;
    end
    in2_valid = 1'b0;
    in2_sof   = 1'b0;
    @(negedge clk);
    chk("d2_valid_end", out2_valid, 1);
    chk("d2_data_end", out2_data, last_d2);
    chk("d2_last_end", out2_last, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("d2_idle", out2_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
